// File: rtl/mem_sram_controller_pkg.sv
// Shared types and constants for the memory-stage SRAM controller.
package mem_sram_controller_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOW  = 2'd1,
        ST_HIGH = 2'd2,
        ST_DONE = 2'd3
    } sram_state_e;

    localparam logic [31:0] DEFAULT_DATA_BASE = 32'd1024;
    localparam int          PHASE_CNT_W       = 3;

    // Byte offset into the data region; wraps modulo 2^32 by construction.
    function automatic logic [31:0] data_offset(input logic [31:0] byte_addr,
                                                input logic [31:0] base);
        return byte_addr - base;
    endfunction

endpackage

// File: rtl/mem_sram_controller_wait_counter.sv
// Phase timer: counts up from 0 while enabled, pulses done on the last cycle of a phase.
module mem_sram_controller_wait_counter
    import mem_sram_controller_pkg::*;
#(
    parameter int SRAM_WAIT = 2
)
(
    input  logic clk,
    input  logic rst,
    input  logic restart,
    input  logic enable,
    output logic done
);

    localparam logic [PHASE_CNT_W-1:0] LAST = PHASE_CNT_W'(SRAM_WAIT - 1);

    logic [PHASE_CNT_W-1:0] count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (restart) begin
            count <= '0;
        end else if (enable) begin
            count <= count + PHASE_CNT_W'(1);
        end
    end

    assign done = enable && (count == LAST);

endmodule

// File: rtl/mem_sram_controller.sv
// Load/store controller for a 16-bit async SRAM; each 32-bit word is two halfword phases.
//
// state | meaning
// IDLE  | waiting for rd_en/wr_en; latches op, address and store data
// LOW   | low halfword on the SRAM for SRAM_WAIT cycles
// HIGH  | high halfword on the SRAM for SRAM_WAIT cycles
// DONE  | one cycle, load data valid, pipeline released
module mem_sram_controller
    import mem_sram_controller_pkg::*;
#(
    parameter logic [31:0] DATA_BASE = DEFAULT_DATA_BASE,
    parameter int          SRAM_WAIT = 2,
    parameter int          SRAM_AW   = 18
)
(
    input  logic               clk,
    input  logic               rst,
    input  logic               rd_en,
    input  logic               wr_en,
    input  logic [31:0]        address,
    input  logic [31:0]        write_data,
    output logic [31:0]        read_data,
    output logic               ready,
    output logic [SRAM_AW-1:0] sram_addr,
    output logic [15:0]        sram_dq_out,
    output logic               sram_dq_oe,
    input  logic [15:0]        sram_dq_in,
    output logic               sram_we_n
);

    sram_state_e        state_q;
    sram_state_e        state_d;
    logic               request;
    logic               op_write_q;
    logic [SRAM_AW-2:0] index_q;
    logic [15:0]        wdata_hi_q;
    logic [31:0]        offset;
    logic [SRAM_AW-2:0] word_idx;
    logic               offset_unused;
    logic               phase_done;
    logic               phase_restart;
    logic               phase_active;

    assign request  = rd_en | wr_en;
    assign offset   = data_offset(address, DATA_BASE);
    assign word_idx = offset[SRAM_AW:2];
    // Sub-word bits and bits above the SRAM range are intentionally dropped.
    assign offset_unused = ^{offset[31:SRAM_AW+1], offset[1:0]};

    assign phase_active  = (state_q == ST_LOW) || (state_q == ST_HIGH);
    assign phase_restart = (state_d != state_q);

    mem_sram_controller_wait_counter #(
        .SRAM_WAIT (SRAM_WAIT)
    ) u_wait_counter (
        .clk     (clk),
        .rst     (rst),
        .restart (phase_restart),
        .enable  (phase_active),
        .done    (phase_done)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (request)    state_d = ST_LOW;
            ST_LOW:  if (phase_done) state_d = ST_HIGH;
            ST_HIGH: if (phase_done) state_d = ST_DONE;
            ST_DONE:                 state_d = ST_IDLE;
            default:                 state_d = ST_IDLE;
        endcase
    end

    assign ready = ((state_q == ST_IDLE) && !request) || (state_q == ST_DONE);

    // SRAM strobes are registered so we_n/oe never glitch on the pads.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            op_write_q  <= 1'b0;
            index_q     <= '0;
            wdata_hi_q  <= '0;
            read_data   <= '0;
            sram_addr   <= '0;
            sram_dq_out <= '0;
            sram_dq_oe  <= 1'b0;
            sram_we_n   <= 1'b1;
        end else begin
            state_q <= state_d;
            case (state_q)
                ST_IDLE: begin
                    if (request) begin
                        op_write_q  <= wr_en;
                        index_q     <= word_idx;
                        wdata_hi_q  <= write_data[31:16];
                        sram_addr   <= {word_idx, 1'b0};
                        sram_dq_out <= wr_en ? write_data[15:0] : 16'h0000;
                        sram_dq_oe  <= wr_en;
                        sram_we_n   <= ~wr_en;
                    end
                end
                ST_LOW: begin
                    if (phase_done) begin
                        if (!op_write_q) begin
                            read_data[15:0] <= sram_dq_in;
                        end
                        sram_addr   <= {index_q, 1'b1};
                        sram_dq_out <= op_write_q ? wdata_hi_q : 16'h0000;
                    end
                end
                ST_HIGH: begin
                    if (phase_done) begin
                        if (!op_write_q) begin
                            read_data[31:16] <= sram_dq_in;
                        end
                        sram_dq_out <= 16'h0000;
                        sram_dq_oe  <= 1'b0;
                        sram_we_n   <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_sram_controller.sv
// Directed bench for mem_sram_controller with a behavioural 16-bit SRAM.
module tb_mem_sram_controller;

    localparam int W  = 2;
    localparam int AW = 18;

    logic          clk;
    logic          rst;
    logic          rd_en;
    logic          wr_en;
    logic [31:0]   address;
    logic [31:0]   write_data;
    logic [31:0]   read_data;
    logic          ready;
    logic [AW-1:0] sram_addr;
    logic [15:0]   sram_dq_out;
    logic          sram_dq_oe;
    logic [15:0]   sram_dq_in;
    logic          sram_we_n;

    logic [15:0] mem [0:255];

    int checks   = 0;
    int failures = 0;

    mem_sram_controller #(
        .DATA_BASE (32'd1024),
        .SRAM_WAIT (W),
        .SRAM_AW   (AW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .rd_en       (rd_en),
        .wr_en       (wr_en),
        .address     (address),
        .write_data  (write_data),
        .read_data   (read_data),
        .ready       (ready),
        .sram_addr   (sram_addr),
        .sram_dq_out (sram_dq_out),
        .sram_dq_oe  (sram_dq_oe),
        .sram_dq_in  (sram_dq_in),
        .sram_we_n   (sram_we_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign sram_dq_in = mem[sram_addr[7:0]];

    always @(posedge clk) begin
        if (!sram_we_n && sram_dq_oe) begin
            mem[sram_addr[7:0]] <= sram_dq_out;
        end
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Starts at #1 after a rising edge; returns #1 after the edge that ends DONE.
    task automatic run_access(input logic rd, input logic wr,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [17:0] base, input logic [31:0] exp_rd,
                              input string tag);
        logic [17:0] ea;
        logic [15:0] ehw;
        rd_en      = rd;
        wr_en      = wr;
        address    = addr;
        write_data = wdata;
        for (int c = 0; c <= 2*W+1; c++) begin
            @(negedge clk);
            if (c == 0) begin
                check_val($sformatf("%s_c0_ready", tag), {31'b0, ready}, 32'd0);
                check_val($sformatf("%s_c0_we_n", tag), {31'b0, sram_we_n}, 32'd1);
            end else if (c <= 2*W) begin
                ea  = (c <= W) ? base : base + 18'd1;
                ehw = (c <= W) ? wdata[15:0] : wdata[31:16];
                check_val($sformatf("%s_c%0d_ready", tag, c), {31'b0, ready}, 32'd0);
                check_val($sformatf("%s_c%0d_addr", tag, c), {14'b0, sram_addr}, {14'b0, ea});
                check_val($sformatf("%s_c%0d_we_n", tag, c), {31'b0, sram_we_n}, {31'b0, ~wr});
                check_val($sformatf("%s_c%0d_oe", tag, c), {31'b0, sram_dq_oe}, {31'b0, wr});
                if (wr) begin
                    check_val($sformatf("%s_c%0d_dq", tag, c), {16'b0, sram_dq_out}, {16'b0, ehw});
                end
            end else begin
                check_val($sformatf("%s_done_ready", tag), {31'b0, ready}, 32'd1);
                check_val($sformatf("%s_done_we_n", tag), {31'b0, sram_we_n}, 32'd1);
                check_val($sformatf("%s_done_oe", tag), {31'b0, sram_dq_oe}, 32'd0);
                check_val($sformatf("%s_done_rdata", tag), read_data, exp_rd);
            end
            @(posedge clk);
            #1;
            if (c == 0) begin
                address    = 32'h0000_0000;
                write_data = ~wdata;
            end
        end
    endtask

    task automatic idle(input int n);
        rd_en = 1'b0;
        wr_en = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
        mem[8] = 16'hCAFE;
        mem[9] = 16'h1234;

        rst        = 1'b0;
        rd_en      = 1'b0;
        wr_en      = 1'b0;
        address    = 32'd0;
        write_data = 32'd0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check_val("rst_ready", {31'b0, ready}, 32'd1);
        check_val("rst_rdata", read_data, 32'd0);
        check_val("rst_we_n", {31'b0, sram_we_n}, 32'd1);
        check_val("rst_oe", {31'b0, sram_dq_oe}, 32'd0);
        check_val("rst_addr", {14'b0, sram_addr}, 32'd0);
        check_val("rst_dq", {16'b0, sram_dq_out}, 32'd0);
        rd_en = 1'b1;
        #1;
        check_val("rst_ready_req", {31'b0, ready}, 32'd0);
        rd_en = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        idle(2);

        run_access(1'b0, 1'b1, 32'd1028, 32'hDEAD_BEEF, 18'd2, 32'h0, "wr1028");
        idle(1);
        check_val("mem2", {16'b0, mem[2]}, 32'h0000_BEEF);
        check_val("mem3", {16'b0, mem[3]}, 32'h0000_DEAD);

        run_access(1'b1, 1'b0, 32'd1028, 32'h0, 18'd2, 32'hDEAD_BEEF, "rd1028");
        idle(10);
        @(negedge clk);
        check_val("hold_rdata", read_data, 32'hDEAD_BEEF);
        check_val("hold_ready", {31'b0, ready}, 32'd1);
        @(posedge clk);
        #1;

        run_access(1'b1, 1'b0, 32'd1040, 32'h0, 18'd8, 32'h1234_CAFE, "b2b_rd");
        run_access(1'b0, 1'b1, 32'd1048, 32'hA5A5_5A5A, 18'd12, 32'h1234_CAFE, "b2b_wr");
        idle(1);
        check_val("mem12", {16'b0, mem[12]}, 32'h0000_5A5A);
        check_val("mem13", {16'b0, mem[13]}, 32'h0000_A5A5);

        run_access(1'b1, 1'b1, 32'd1024, 32'h1234_5678, 18'd0, 32'h1234_CAFE, "both");
        idle(1);
        check_val("mem0", {16'b0, mem[0]}, 32'h0000_5678);
        check_val("mem1", {16'b0, mem[1]}, 32'h0000_1234);

        run_access(1'b1, 1'b0, 32'd1030, 32'h0, 18'd2, 32'hDEAD_BEEF, "misalign");
        idle(1);

        wr_en      = 1'b1;
        address    = 32'd1056;
        write_data = 32'h0BAD_F00D;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b0;
        #1;
        check_val("abort_we_n", {31'b0, sram_we_n}, 32'd1);
        check_val("abort_oe", {31'b0, sram_dq_oe}, 32'd0);
        check_val("abort_addr", {14'b0, sram_addr}, 32'd0);
        check_val("abort_rdata", read_data, 32'd0);
        check_val("abort_ready_req", {31'b0, ready}, 32'd0);
        wr_en = 1'b0;
        #1;
        check_val("abort_ready_idle", {31'b0, ready}, 32'd1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        idle(1);
        run_access(1'b1, 1'b0, 32'd1028, 32'h0, 18'd2, 32'hDEAD_BEEF, "post_rst_rd");
        idle(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
